// File: rtl/fifo_rr_ctrl_if.sv
// Bus bundle for fifo_rr_ctrl: two write requesters, the RAM ports and the
// registered read interface.  The controller uses the slave view; the
// surrounding logic (requesters, RAM, consumer) uses the master view.
interface fifo_rr_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              i_req0Valid;
    logic [DATA_W-1:0] i_req0Data;
    logic              o_req0Ready;
    logic              i_req1Valid;
    logic [DATA_W-1:0] i_req1Data;
    logic              o_req1Ready;
    logic              o_memWclkEn;
    logic [ADDR_W-1:0] o_memWaddr;
    logic [DATA_W-1:0] o_memWdata;
    logic              o_memWfull;
    logic [ADDR_W-1:0] o_memRaddr;
    logic [DATA_W-1:0] i_memRdata;
    logic              o_rvalid;
    logic [DATA_W-1:0] o_rdata;
    logic              i_rready;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_empty;
    logic              o_almostFull;
    logic              o_lastGrant;

    modport slave (
        input  i_req0Valid, i_req0Data, i_req1Valid, i_req1Data,
        input  i_memRdata, i_rready,
        output o_req0Ready, o_req1Ready,
        output o_memWclkEn, o_memWaddr, o_memWdata, o_memWfull, o_memRaddr,
        output o_rvalid, o_rdata,
        output o_count, o_full, o_empty, o_almostFull, o_lastGrant
    );

    modport master (
        output i_req0Valid, i_req0Data, i_req1Valid, i_req1Data,
        output i_memRdata, i_rready,
        input  o_req0Ready, o_req1Ready,
        input  o_memWclkEn, o_memWaddr, o_memWdata, o_memWfull, o_memRaddr,
        input  o_rvalid, o_rdata,
        input  o_count, o_full, o_empty, o_almostFull, o_lastGrant
    );
endinterface

// File: rtl/fifo_rr_ctrl.sv
// FIFO controller around an external dual-port RAM (combinational read).
// Two requesters share the write port under round-robin arbitration; the
// head word is presented through a registered valid/ready output stage, so
// total capacity is DEPTH words in RAM plus one in the output register.
module fifo_rr_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int AF_LVL = 12
) (
    input  logic            i_clk,
    input  logic            i_rst,
    fifo_rr_ctrl_if.slave   bus
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LVL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              prio_q, prio_d;
    logic              last_grant_q, last_grant_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [PW-1:0]     count;
    logic              full;
    logic              empty;
    logic              load;

    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_data [2];
    logic [1:0]        req_ready;
    logic              grant_vld;
    logic              grant_idx;

    assign req_valid[0] = bus.i_req0Valid;
    assign req_valid[1] = bus.i_req1Valid;
    assign req_data[0]  = bus.i_req0Data;
    assign req_data[1]  = bus.i_req1Data;

    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                   (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

    // A new head word is fetched whenever the output register is free or
    // being consumed; an incoming write never bypasses the RAM.
    assign load = (!rvalid_q || bus.i_rready) && !empty;

    // Round-robin arbiter: a lone requester always wins, a contested cycle
    // goes to the requester named by prio.  Nothing is granted while full.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!full) begin
            if (&req_valid) begin
                grant_vld = 1'b1;
                grant_idx = prio_q;
            end else if (req_valid[0]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (req_valid[1]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    // Each requester's ready is high only in the cycle its word is written.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_vld && (grant_idx == 1'(gi));
        end
    endgenerate

    // Next-state for pointers, arbitration history and output stage.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        prio_d       = prio_q;
        last_grant_d = last_grant_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        if (grant_vld) begin
            wptr_d       = wptr_q + PW'(1);
            prio_d       = ~grant_idx;
            last_grant_d = grant_idx;
        end
        if (load) begin
            rptr_d   = rptr_q + PW'(1);
            rdata_d  = bus.i_memRdata;
            rvalid_d = 1'b1;
        end else if (bus.i_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State register with synchronous reset; RAM contents are simply
    // abandoned because both pointers return to zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            prio_q       <= 1'b0;
            last_grant_q <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            prio_q       <= prio_d;
            last_grant_q <= last_grant_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.o_req0Ready  = req_ready[0];
    assign bus.o_req1Ready  = req_ready[1];
    assign bus.o_memWclkEn  = grant_vld;
    assign bus.o_memWaddr   = wptr_q[ADDR_W-1:0];
    assign bus.o_memWdata   = req_data[grant_idx];
    assign bus.o_memWfull   = full;
    assign bus.o_memRaddr   = rptr_q[ADDR_W-1:0];
    assign bus.o_rvalid     = rvalid_q;
    assign bus.o_rdata      = rdata_q;
    assign bus.o_count      = count;
    assign bus.o_full       = full;
    assign bus.o_empty      = empty;
    assign bus.o_almostFull = (count >= AF_THRESH);
    assign bus.o_lastGrant  = last_grant_q;
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Bench for fifo_rr_ctrl: directed scenarios followed by a random phase,
// all checked cycle by cycle against a queue-based reference model.
module tb_fifo_rr_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rr_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    fifo_rr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .AF_LVL(AF)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // RAM stand-in: synchronous write, combinational read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk)
        if (bus.o_memWclkEn && !bus.o_memWfull) mem[bus.o_memWaddr] <= bus.o_memWdata;
    assign bus.i_memRdata = mem[bus.o_memRaddr];

    logic          req_v [2];
    logic [DW-1:0] req_d [2];
    logic          rready;
    assign bus.i_req0Valid = req_v[0];
    assign bus.i_req0Data  = req_d[0];
    assign bus.i_req1Valid = req_v[1];
    assign bus.i_req1Data  = req_d[1];
    assign bus.i_rready    = rready;

    // Reference model: RAM occupancy as a queue, output register, preference.
    logic [DW-1:0] ref_q [$];
    bit            ref_rv;
    logic [DW-1:0] ref_rdata;
    int            ref_pref;
    int            ref_last;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester k offers a word when asked; an offered word is held until taken.
    task automatic want(int k, bit w);
        if (!req_v[k] && w) begin
            req_v[k] = 1'b1;
            req_d[k] = DW'($urandom);
        end
    endtask

    task automatic drop_all();
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
    endtask

    // One clock: check outputs against the model, cross the edge, update model.
    task automatic tick(bit check);
        int  g;
        bit  full_m;
        bit  load;
        #1;
        full_m = (ref_q.size() == DEPTH);
        g = -1;
        if (!full_m) begin
            if (req_v[0] && req_v[1]) g = ref_pref;
            else if (req_v[0])        g = 0;
            else if (req_v[1])        g = 1;
        end
        if (check) begin
            chk("ready0", 32'(bus.o_req0Ready), 32'(g == 0));
            chk("ready1", 32'(bus.o_req1Ready), 32'(g == 1));
            chk("wen", 32'(bus.o_memWclkEn), 32'(g >= 0));
            chk("count", 32'(bus.o_count), 32'(ref_q.size()));
            chk("empty", 32'(bus.o_empty), 32'(ref_q.size() == 0));
            chk("full", 32'(bus.o_full), 32'(full_m));
            chk("almost_full", 32'(bus.o_almostFull), 32'(ref_q.size() >= AF));
            chk("rvalid", 32'(bus.o_rvalid), 32'(ref_rv));
            chk("rdata", 32'(bus.o_rdata), 32'(ref_rdata));
            chk("last_grant", 32'(bus.o_lastGrant), 32'(ref_last));
            if (g >= 0) chk("wdata", 32'(bus.o_memWdata), 32'(req_d[g]));
        end
        load = (!ref_rv || rready) && (ref_q.size() > 0);
        @(posedge clk);
        @(negedge clk);
        if (rst) begin
            ref_q.delete();
            ref_rv    = 1'b0;
            ref_rdata = '0;
            ref_pref  = 0;
            ref_last  = 0;
        end else begin
            if (load) begin
                ref_rdata = ref_q.pop_front();
                ref_rv    = 1'b1;
                $display("[TB] t=%0t pop  %02h", $time, ref_rdata);
            end else if (rready) begin
                ref_rv = 1'b0;
            end
            if (g >= 0) begin
                ref_q.push_back(req_d[g]);
                ref_pref = 1 - g;
                ref_last = g;
                req_v[g] = 1'b0;
                $display("[TB] t=%0t push req%0d %02h count=%0d", $time, g, req_d[g], ref_q.size());
            end
        end
    endtask

    initial begin
        drop_all();
        req_d[0] = '0;
        req_d[1] = '0;
        rready   = 1'b0;
        ref_q.delete();
        ref_rv = 1'b0; ref_rdata = '0; ref_pref = 0; ref_last = 0;

        // Reset and reset-state check
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        #1;
        chk("rst_empty", 32'(bus.o_empty), 32'd1);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
        chk("rst_rdata", 32'(bus.o_rdata), 32'd0);

        // Single word from req0, visible two edges after acceptance
        req_v[0] = 1'b1;
        req_d[0] = 8'hA1;
        tick(1'b1);
        tick(1'b1);
        chk("t1_rvalid", 32'(bus.o_rvalid), 32'd1);
        chk("t1_rdata", 32'(bus.o_rdata), 32'hA1);
        rready = 1'b1;
        tick(1'b1);
        rready = 1'b0;

        // Both requesters continuously valid, consumer always ready
        rready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            want(0, 1'b1);
            want(1, 1'b1);
            tick(1'b1);
        end

        // Fill with consumer stalled: almost-full, then full, readies drop
        rst = 1'b1; drop_all(); tick(1'b0); rst = 1'b0;
        rready = 1'b0;
        for (int i = 0; i < 22; i++) begin
            want(0, 1'b1);
            want(1, 1'b1);
            tick(1'b1);
        end
        chk("t3_full", 32'(bus.o_full), 32'd1);
        chk("t3_count", 32'(bus.o_count), 32'd16);

        // Full and pop in the same cycle: the write stays blocked
        rready = 1'b1;
        tick(1'b1);

        // Drain to empty in arrival order
        drop_all();
        for (int i = 0; i < 20; i++) tick(1'b1);
        chk("t4_empty", 32'(bus.o_empty), 32'd1);
        chk("t4_rvalid", 32'(bus.o_rvalid), 32'd0);

        // Build count 5, then one write plus one pop per cycle across wraps
        rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            want(0, 1'b1);
            tick(1'b1);
        end
        rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            want(0, 1'b1);
            #1;
            chk("t5_count", 32'(bus.o_count), 32'd5);
            tick(1'b1);
        end

        // Reset mid-operation with count 7 and a valid output word
        rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            want(0, 1'b1);
            tick(1'b1);
        end
        chk("t6_pre_count", 32'(bus.o_count), 32'd7);
        drop_all();
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        #1;
        chk("t6_empty", 32'(bus.o_empty), 32'd1);
        chk("t6_count", 32'(bus.o_count), 32'd0);
        chk("t6_rvalid", 32'(bus.o_rvalid), 32'd0);
        want(0, 1'b1);
        want(1, 1'b1);
        #1;
        chk("t6_first_grant", 32'(bus.o_req0Ready), 32'd1);
        tick(1'b1);

        // Random traffic with alternating fill-biased and drain-biased phases
        for (int i = 0; i < 400; i++) begin
            want(0, ($urandom % 3) != 0);
            want(1, ($urandom % 2) != 0);
            if ((i % 64) < 32) rready = (($urandom % 4) == 0);
            else               rready = (($urandom % 4) != 0);
            tick(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
